imem_boot_loader: RTL and testbench

- Sits directly upstream of the instruction memory and the single-cycle core.
- Accepts a byte stream (valid/ready) from a host link and packs it little-endian into 32-bit words.
- Writes those words through the instruction memory write port.
- Holds the core in reset (core_rst_n low) until the image is fully written, then releases it.
- Can re-enter load mode on request.

---
 rtl/imem_boot_loader_pkg.sv | 21 ++
 rtl/imem_boot_loader_byte_packer.sv | 48 ++++
 rtl/imem_boot_loader.sv | 146 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_pkg
// Shared definitions for the instruction-memory boot loader:
//   - loader_state_e : loader FSM states (header low byte, header high byte,
//                      image data, core running)
//   - ADDR_W_DEFAULT : default word-address width of the instruction memory
//   - CNT_W_DEFAULT  : default width of the image word-count header
// ---------------------------------------------------------------------------
package imem_boot_loader_pkg;

    typedef enum logic [1:0] {
        LEN0 = 2'd0,
        LEN1 = 2'd1,
        DATA = 2'd2,
        RUN  = 2'd3
    } loader_state_e;

    localparam int ADDR_W_DEFAULT = 10;
    localparam int CNT_W_DEFAULT  = 16;

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_byte_packer
// Packs accepted bytes little-endian into 32-bit words.
// Ports:
//   clk, rst_n   : clock and asynchronous active-low reset
//   clear_i      : synchronous clear of lane counter and partial word
//   accept_i     : a byte is being accepted this cycle
//   byte_i       : the byte being accepted
//   word_o       : complete word (valid while word_done_o is high)
//   word_done_o  : high in the cycle the lane-3 byte is accepted
// ---------------------------------------------------------------------------
module imem_boot_loader_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    logic [1:0]  lane_q;
    logic [23:0] partial_q;

    // Lanes 0..2 are stored; lane 3 is taken straight from the input so the
    // full word is available in the same cycle the last byte arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q    <= 2'd0;
            partial_q <= 24'd0;
        end else if (clear_i) begin
            lane_q    <= 2'd0;
            partial_q <= 24'd0;
        end else if (accept_i) begin
            case (lane_q)
                2'd0:    partial_q[7:0]   <= byte_i;
                2'd1:    partial_q[15:8]  <= byte_i;
                2'd2:    partial_q[23:16] <= byte_i;
                default: partial_q        <= partial_q;
            endcase
            lane_q <= lane_q + 2'd1;
        end
    end

    assign word_o      = {byte_i, partial_q};
    assign word_done_o = accept_i && (lane_q == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
// Receives a boot image over a byte stream (16-bit little-endian word count
// followed by the words, little-endian), writes it into the instruction
// memory and holds the core in reset until the image is complete.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   rx_data/valid/ready: byte stream from the host link
//   load_req           : reload request, only honoured while running
//   im_we/waddr/wdata  : instruction memory write port
//   core_rst_n         : active-low reset to the core
//   busy               : loader not in RUN
//   err                : sticky, header count larger than the memory
//   words_loaded       : complete words received in this load
// ---------------------------------------------------------------------------
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              load_req,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  words_loaded
);

    localparam logic [31:0] DEPTH = 32'(1 << ADDR_W);

    loader_state_e     state_q;
    logic [7:0]        count_lo_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  words_q;
    logic              err_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic              core_rst_n_q;

    logic              accept;
    logic              reload;
    logic [CNT_W-1:0]  count_d;
    logic [CNT_W-1:0]  words_d;
    logic [31:0]       packed_word;
    logic              word_done;

    // Ready depends on state only, so the host may wait on it safely.
    assign rx_ready = (state_q != RUN);
    assign busy     = (state_q != RUN);
    assign accept   = rx_valid && rx_ready;
    assign reload   = (state_q == RUN) && load_req;
    assign count_d  = CNT_W'({rx_data, count_lo_q});
    assign words_d  = words_q + CNT_W'(1);

    imem_boot_loader_byte_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (reload),
        .accept_i    (accept && (state_q == DATA)),
        .byte_i      (rx_data),
        .word_o      (packed_word),
        .word_done_o (word_done)
    );

    // Loader FSM with registered outputs. Words beyond the memory depth are
    // still counted but their write pulse is suppressed. The core is only
    // released once no write pulse is pending, so it never leaves reset in
    // the same cycle as a memory write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LEN0;
            count_lo_q   <= 8'd0;
            count_q      <= '0;
            words_q      <= '0;
            err_q        <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= 32'd0;
            core_rst_n_q <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                LEN0: begin
                    if (accept) begin
                        count_lo_q <= rx_data;
                        state_q    <= LEN1;
                    end
                end
                LEN1: begin
                    if (accept) begin
                        count_q <= count_d;
                        if (count_d == '0) begin
                            state_q <= RUN;
                        end else begin
                            state_q <= DATA;
                            if (32'(count_d) > DEPTH) begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                DATA: begin
                    if (word_done) begin
                        wdata_q <= packed_word;
                        waddr_q <= words_q[ADDR_W-1:0];
                        we_q    <= (32'(words_q) < DEPTH);
                        words_q <= words_d;
                        if (words_d == count_q) begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (load_req) begin
                        state_q      <= LEN0;
                        core_rst_n_q <= 1'b0;
                        err_q        <= 1'b0;
                        words_q      <= '0;
                        count_q      <= '0;
                        count_lo_q   <= 8'd0;
                    end else if (!we_q) begin
                        core_rst_n_q <= 1'b1;
                    end
                end
                default: state_q <= LEN0;
            endcase
        end
    end

    assign im_we        = we_q;
    assign im_waddr     = waddr_q;
    assign im_wdata     = wdata_q;
    assign core_rst_n   = core_rst_n_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
// Bench for imem_boot_loader with a 4-word memory (ADDR_W = 2) so that
// overflow images are cheap to build.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

    localparam int ADDR_W = 2;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              load_req = 1'b0;
    logic              im_we;
    logic [ADDR_W-1:0] im_waddr;
    logic [31:0]       im_wdata;
    logic              core_rst_n;
    logic              busy;
    logic              err;
    logic [CNT_W-1:0]  words_loaded;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t obsWrites[$];
    int  acceptCyc[$];
    int  cycleCnt = 0;
    int  riseCycle = -1;
    bit  overlapSeen = 1'b0;
    logic prevCore = 1'b0;
    int  testsRun = 0;
    int  testsFailed = 0;

    imem_boot_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .load_req     (load_req),
        .im_we        (im_we),
        .im_waddr     (im_waddr),
        .im_wdata     (im_wdata),
        .core_rst_n   (core_rst_n),
        .busy         (busy),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Edge index: after rising edge N, cycleCnt == N.
    always @(posedge clk) cycleCnt = cycleCnt + 1;

    // Observe the write port and core reset on the falling edge.
    always @(negedge clk) begin
        if (im_we) obsWrites.push_back('{int'(im_waddr), im_wdata, cycleCnt});
        if (im_we && core_rst_n) overlapSeen = 1'b1;
        if (core_rst_n && !prevCore) riseCycle = cycleCnt;
        prevCore = core_rst_n;
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    // Offer one byte after an optional idle gap; returns after it is taken.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
        int waitCnt;
        waitCnt = 0;
        repeat (gap) begin
            @(negedge clk);
            load_req = noise ? 1'($urandom % 2) : 1'b0;
        end
        @(negedge clk);
        load_req = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!rx_ready) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL handshake: rx_ready=%0b required 1", rx_ready);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acceptCyc.push_back(cycleCnt);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Stream a full image and compare everything against what the image
    // header and payload imply.
    task automatic test_load_image(input logic [7:0] img[$], input int gapMin,
                                   input int gapMax, input bit noise, input string name);
        int          count;
        int          expWrites;
        int          expRise;
        logic [31:0] expData;
        obsWrites.delete();
        acceptCyc.delete();
        riseCycle   = -1;
        overlapSeen = 1'b0;
        count = int'({img[1], img[0]});
        for (int i = 0; i < img.size(); i++) begin
            send_byte(img[i], int'($urandom_range(gapMax, gapMin)), noise);
            if (i == 1) begin
                testsRun++;
                if (err !== (count > DEPTH)) begin
                    testsFailed++;
                    $display("[TB] FAIL %s err_after_header: got %0b required %0b", name, err, count > DEPTH);
                end
                if (count > 0) begin
                    testsRun++;
                    if (busy !== 1'b1 || core_rst_n !== 1'b0) begin
                        testsFailed++;
                        $display("[TB] FAIL %s loading_flags: busy=%0b core_rst_n=%0b required 1/0", name, busy, core_rst_n);
                    end
                end
            end
        end
        repeat (6) @(negedge clk);
        expWrites = (count < DEPTH) ? count : DEPTH;
        testsRun++;
        if (obsWrites.size() != expWrites) begin
            testsFailed++;
            $display("[TB] FAIL %s write_count: got %0d required %0d", name, obsWrites.size(), expWrites);
        end
        for (int w = 0; w < expWrites && w < obsWrites.size(); w++) begin
            expData = {img[5+4*w], img[4+4*w], img[3+4*w], img[2+4*w]};
            testsRun++;
            if (obsWrites[w].addr != w || obsWrites[w].data !== expData) begin
                testsFailed++;
                $display("[TB] FAIL %s write%0d: got addr %0d data %h required addr %0d data %h",
                         name, w, obsWrites[w].addr, obsWrites[w].data, w, expData);
            end
            testsRun++;
            if (obsWrites[w].cyc != acceptCyc[5+4*w]) begin
                testsFailed++;
                $display("[TB] FAIL %s write%0d_timing: got cycle %0d required %0d",
                         name, w, obsWrites[w].cyc, acceptCyc[5+4*w]);
            end
        end
        expRise = acceptCyc[acceptCyc.size()-1] + ((count > 0 && count <= DEPTH) ? 2 : 1);
        testsRun++;
        if (riseCycle != expRise) begin
            testsFailed++;
            $display("[TB] FAIL %s core_release: got cycle %0d required %0d", name, riseCycle, expRise);
        end
        testsRun++;
        if (int'(words_loaded) != count) begin
            testsFailed++;
            $display("[TB] FAIL %s words_loaded: got %0d required %0d", name, words_loaded, count);
        end
        testsRun++;
        if (err !== (count > DEPTH)) begin
            testsFailed++;
            $display("[TB] FAIL %s err_final: got %0b required %0b", name, err, count > DEPTH);
        end
        testsRun++;
        if (busy !== 1'b0 || rx_ready !== 1'b0 || core_rst_n !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL %s run_flags: busy=%0b rx_ready=%0b core_rst_n=%0b required 0/0/1",
                     name, busy, rx_ready, core_rst_n);
        end
        testsRun++;
        if (overlapSeen !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL %s write_release_overlap: got %0b required 0", name, overlapSeen);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        testsRun++;
        if (im_we !== 1'b0 || im_waddr !== '0 || im_wdata !== 32'd0 || core_rst_n !== 1'b0 ||
            busy !== 1'b1 || err !== 1'b0 || words_loaded !== '0 || rx_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_values: we=%0b addr=%0d data=%h core=%0b busy=%0b err=%0b words=%0d ready=%0b required 0/0/0/0/1/0/0/1",
                     im_we, im_waddr, im_wdata, core_rst_n, busy, err, words_loaded, rx_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reload();
        testsRun++;
        if (busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reload_precondition: busy=%0b required 0", busy);
        end
        @(negedge clk);
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        testsRun++;
        if (core_rst_n !== 1'b0 || rx_ready !== 1'b1 || err !== 1'b0 || busy !== 1'b1 || words_loaded !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reload: core=%0b ready=%0b err=%0b busy=%0b words=%0d required 0/1/0/1/0",
                     core_rst_n, rx_ready, err, busy, words_loaded);
        end
    endtask

    task automatic test_basic();
        logic [7:0] img[$];
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        test_load_image(img, 0, 0, 1'b0, "basic");
        testsRun++;
        if (obsWrites.size() != 2 || obsWrites[0].data !== 32'h00A00513 || obsWrites[1].data !== 32'h00B00593) begin
            testsFailed++;
            $display("[TB] FAIL basic_words: got %0d writes, first %h, required 2 writes 00a00513/00b00593",
                     obsWrites.size(), (obsWrites.size() > 0) ? obsWrites[0].data : 32'h0);
        end
    endtask

    task automatic test_throttled();
        logic [7:0] img[$];
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        test_load_image(img, 2, 2, 1'b0, "throttled");
    endtask

    task automatic test_zero_length();
        logic [7:0] img[$];
        img = '{8'h00, 8'h00};
        test_load_image(img, 0, 0, 1'b0, "zero_length");
    endtask

    task automatic test_overflow();
        logic [7:0] img[$];
        img = '{8'h05, 8'h00};
        for (int i = 0; i < 20; i++) img.push_back(8'($urandom));
        test_load_image(img, 0, 1, 1'b0, "overflow");
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] img[$];
        obsWrites.delete();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        testsRun++;
        if (busy !== 1'b1 || words_loaded !== '0 || obsWrites.size() != 0 || core_rst_n !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mid_word_reset: busy=%0b words=%0d writes=%0d core=%0b required 1/0/0/0",
                     busy, words_loaded, obsWrites.size(), core_rst_n);
        end
        @(negedge clk);
        rst_n = 1'b1;
        img = '{8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        test_load_image(img, 0, 0, 1'b0, "after_reset");
        testsRun++;
        if (obsWrites.size() != 1 || obsWrites[0].data !== 32'hEFBEADDE) begin
            testsFailed++;
            $display("[TB] FAIL after_reset_word: got %0d writes, first %h, required 1 write efbeadde",
                     obsWrites.size(), (obsWrites.size() > 0) ? obsWrites[0].data : 32'h0);
        end
    endtask

    task automatic test_random();
        logic [7:0] img[$];
        int         count;
        for (int it = 0; it < 8; it++) begin
            count = int'($urandom_range(6, 0));
            img.delete();
            img.push_back(8'(count));
            img.push_back(8'h00);
            for (int i = 0; i < 4 * count; i++) img.push_back(8'($urandom));
            test_load_image(img, 0, 3, 1'b1, "random");
            test_reload();
        end
    endtask

    // Scenarios run in order; each one leaves the loader in RUN so the
    // following reload exercises the RUN -> LEN0 path.
    initial begin
        test_reset();
        test_basic();
        test_reload();
        test_throttled();
        test_reload();
        test_zero_length();
        test_reload();
        test_overflow();
        test_reload();
        test_reset_mid_word();
        test_reload();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
